door_open_timer: RTL
====================

Name: door_open_timer

Overview:
- Consumer end of the 1 Hz time base produced by the frequency divider.
- Samples the divided C_1Hz signal back in the 100 MHz domain, turns each rising edge into a one-cycle seconds tick, and uses that tick to run the elevator door-open countdown (maximum door-open time 10 s).
- Sits between the divider and the elevator control FSM. The FSM requests the door open or closed; this block reports door state, remaining seconds and a timeout pulse.

Parameters:
- T_ABIERTA, 10, door-open time in seconds loaded on open/reload; legal range 1..(2^CNT_W - 1).
- CNT_W, 4, width of the seconds countdown.
- SYNC_STAGES, 2, number of synchronizer flops on C_1Hz (minimum 2).

Ports:
- C_100Mhz  input  1  system clock, 100 MHz.
- Rst_n  input  1  asynchronous, active-low reset.
- C_1Hz  input  1  divided clock from the frequency divider; rising edge once per second; treated as asynchronous.
- abrir  input  1  open request from the control FSM; level, sampled every cycle.
- cerrar  input  1  early-close request; level.
- obstaculo  input  1  door obstruction sensor; level, high = blocked.
- puerta_abierta  output  1  door open command.
- restante  output  CNT_W  seconds remaining.
- timeout  output  1  one-cycle pulse when the door closes (expiry or early close).
- seg_tick  output  1  registered one-cycle pulse per detected C_1Hz rising edge.
- estado  output  2  FSM state: 0 CERRADA, 1 ABIERTA, 2 EXPIRA.

Behaviour:
- Reset (Rst_n=0, async):
  - estado=CERRADA; puerta_abierta=0, restante=0, timeout=0, seg_tick=0.
  - All synchronizer flops and the edge-detect flop reset to 1. C_1Hz already high at reset release therefore produces no spurious tick; the first tick comes from the next genuine rising edge.
- Tick path:
  - C_1Hz passes through SYNC_STAGES flops, then one edge-detect flop.
  - The internal tick is the last sync stage high and the edge-detect flop low.
  - seg_tick is that tick registered. With the default, seg_tick is high exactly in cycle 3 after the first clock edge that samples C_1Hz=1, for exactly 1 cycle per rising edge.
  - FSM decisions use the internal tick, so they happen in the same cycle seg_tick asserts.
- CERRADA:
  - puerta_abierta=0, restante=0.
  - abrir=1 or obstaculo=1 → ABIERTA next cycle with restante=T_ABIERTA and puerta_abierta=1.
  - cerrar and ticks are ignored.
- ABIERTA: puerta_abierta=1. Per-cycle priority, highest first:
  1. obstaculo=1 → restante reloaded to T_ABIERTA, stay ABIERTA. Overrides cerrar and tick.
  2. abrir=1 → restante reloaded to T_ABIERTA, stay ABIERTA. Overrides cerrar and tick.
  3. cerrar=1 → EXPIRA next cycle.
  4. tick with restante==1 → EXPIRA next cycle, restante=0.
  5. tick with restante>1 → restante-1.
  6. Otherwise hold.
- EXPIRA:
  - Lasts exactly 1 cycle; timeout=1, puerta_abierta=0, restante=0.
  - Inputs are ignored; transitions unconditionally to CERRADA.
  - A request present in the following cycle reopens via CERRADA, so the minimum close-to-reopen gap is 2 cycles.
- Timing and width rules:
  - restante never wraps and never goes below 0.
  - The countdown is not phase-aligned: the first decrement happens at the first tick after entry, so actual open time is in (T_ABIERTA-1, T_ABIERTA] seconds.
  - estado encoding 3 is unreachable; if it ever occurs, the FSM goes to CERRADA next cycle.
  - All outputs are registered; no combinational input-to-output path.
- Reset mid-operation: async forces the reset values immediately, including while in ABIERTA or EXPIRA; any pending tick is discarded.

Test Plan:
- Reset with C_1Hz held high, release, keep C_1Hz high 50 cycles → seg_tick never asserts; estado=0, all outputs 0.
- Drive C_1Hz with a 20-cycle period (bench-scaled); pulse abrir 1 cycle → puerta_abierta=1 and restante=10 on the next cycle. restante steps 10→9→…→1 on successive seg_tick pulses. The 10th tick gives estado=2 with timeout=1 for exactly 1 cycle, then estado=0 with puerta_abierta=0.
- Open, let restante reach 4, hold obstaculo=1 across 3 ticks → restante stays 10 the whole time. Release → countdown resumes from 10.
- Open, at restante=7 assert cerrar=1 → one-cycle timeout and door closed. Repeat with cerrar and obstaculo asserted together → stays ABIERTA, restante=10.
- In ABIERTA at restante=1, assert abrir in the same cycle as a tick → restante=10, no timeout. Then check a tick with restante=1 and no requests → EXPIRA and restante=0, with no underflow to 15.
- Assert Rst_n=0 mid-countdown (restante=5) for 1 cycle, off the clock edge → outputs go to reset values asynchronously. After release the next rising edge of C_1Hz yields exactly one seg_tick.

Source files
------------

// File: rtl/door_open_timer.sv
// door_open_timer
//   Brings the divided 1 Hz clock into the 100 MHz domain, converts each of
//   its rising edges into a one-cycle seconds tick, and uses that tick to run
//   the elevator door-open countdown. The control FSM requests open/close.
//   This block reports the door state, the remaining seconds and a
//   close-event pulse.
//
// Ports
//   C_100Mhz        system clock
//   Rst_n           asynchronous active-low reset
//   C_1Hz           divided clock, asynchronous to C_100Mhz
//   abrir           open request (level)
//   cerrar          early-close request (level)
//   obstaculo       door obstruction sensor, high = blocked (level)
//   puerta_abierta  door open command
//   restante        seconds remaining on the countdown
//   timeout         one-cycle pulse when the door closes
//   seg_tick        one-cycle pulse per detected C_1Hz rising edge
//   estado          0 CERRADA, 1 ABIERTA, 2 EXPIRA
module door_open_timer #(
   parameter int T_ABIERTA   = 10,
   parameter int CNT_W       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             C_100Mhz,
   input  logic             Rst_n,
   input  logic             C_1Hz,
   input  logic             abrir,
   input  logic             cerrar,
   input  logic             obstaculo,
   output logic             puerta_abierta,
   output logic [CNT_W-1:0] restante,
   output logic             timeout,
   output logic             seg_tick,
   output logic [1:0]       estado
);

   typedef enum logic [1:0] {
      CERRADA = 2'd0,
      ABIERTA = 2'd1,
      EXPIRA  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] T_LOAD = CNT_W'(T_ABIERTA);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   tick;
   state_t                 state;

   // Synchronizer and edge flop reset high. A C_1Hz that is already high at
   // reset release therefore looks like "no change" and produces no tick.
   always_ff @(posedge C_100Mhz or negedge Rst_n) begin
      if (!Rst_n) begin
         sync     <= '1;
         prev     <= 1'b1;
         seg_tick <= 1'b0;
      end else begin
         sync     <= {sync[SYNC_STAGES-2:0], C_1Hz};
         prev     <= sync[SYNC_STAGES-1];
         seg_tick <= tick;
      end
   end

   assign tick = sync[SYNC_STAGES-1] & ~prev;

   // The FSM acts on the internal tick, so its effect lands in the same
   // cycle that seg_tick asserts.
   always_ff @(posedge C_100Mhz or negedge Rst_n) begin
      if (!Rst_n) begin
         state          <= CERRADA;
         puerta_abierta <= 1'b0;
         restante       <= '0;
         timeout        <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            CERRADA: begin
               puerta_abierta <= 1'b0;
               restante       <= '0;
               if (abrir || obstaculo) begin
                  state          <= ABIERTA;
                  puerta_abierta <= 1'b1;
                  restante       <= T_LOAD;
               end
            end
            ABIERTA: begin
               puerta_abierta <= 1'b1;
               if (obstaculo || abrir) begin
                  restante <= T_LOAD;
               end else if (cerrar || (tick && restante <= ONE)) begin
                  // The <= also covers a zero count, so it can never wrap.
                  state          <= EXPIRA;
                  puerta_abierta <= 1'b0;
                  restante       <= '0;
                  timeout        <= 1'b1;
               end else if (tick) begin
                  restante <= restante - ONE;
               end
            end
            EXPIRA: begin
               state          <= CERRADA;
               puerta_abierta <= 1'b0;
               restante       <= '0;
            end
            default: begin
               state          <= CERRADA;
               puerta_abierta <= 1'b0;
               restante       <= '0;
            end
         endcase
      end
   end

   assign estado = state;

endmodule
